// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: shares one SRAM between instruction fetch and MEM-stage loads/stores.
// Each MEM access runs as a multi-cycle SRAM cycle and raises a stall until it is done.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_req/we/addr/wdata    MEM stage access request
//   mem_rdata                load result, valid from the DONE cycle and then held
//   if_addr, if_inst         fetch address and fetched instruction (NOP_INST while busy)
//   stall_request_from_mem   combinational stall request
//   sram_*                   SRAM address, data and active-low control strobes
module mem_bus_ctrl #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16,
   parameter int WAIT_CYCLES = 2,
   parameter logic [DATA_W-1:0] NOP_INST = 16'h0800
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_inst,
   output logic              stall_request_from_mem,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   output logic              sram_wdata_oe,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);
   localparam int CW = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] W = CW'(WAIT_CYCLES);
   typedef enum logic [1:0] {IDLE, MEM_ACC, DONE} state_t;
   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              w_acc;
   logic              w_busy;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: if (mem_req) begin
               r_state <= MEM_ACC;
               r_cnt   <= W;
               r_addr  <= mem_addr;
               r_we    <= mem_we;
               r_wdata <= mem_wdata;
            end
            MEM_ACC: if (r_cnt == '0) begin
               r_state <= DONE;
               if (!r_we) r_rdata <= sram_rdata;
            end else r_cnt <= r_cnt - 1'b1;
            default: r_state <= IDLE;
         endcase
      end
   end
   always_comb begin
      w_acc                  = r_state == MEM_ACC;
      w_busy                 = w_acc | (r_state == IDLE & mem_req);
      stall_request_from_mem = !rst & w_busy;
      if_inst                = (rst | w_busy) ? NOP_INST : sram_rdata;
      sram_addr              = w_acc ? r_addr : if_addr;
      sram_wdata             = r_wdata;
      sram_wdata_oe          = !rst & w_acc & r_we;
      sram_ce_n              = rst;
      sram_oe_n              = rst | (w_acc & r_we);
      // write strobe skips the first (setup) and last (hold) access cycles
      sram_we_n              = !(sram_wdata_oe && r_cnt != W && r_cnt != '0);
      mem_rdata              = r_rdata;
   end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed vector and sequence checks for mem_bus_ctrl.
module tb_mem_bus_ctrl;
   logic        clk = 1'b0;
   logic        rst, mem_req, mem_we;
   logic [17:0] mem_addr, if_addr, sram_addr;
   logic [15:0] mem_wdata, mem_rdata, if_inst, sram_wdata, sram_rdata;
   logic        stall, sram_wdata_oe, sram_ce_n, sram_oe_n, sram_we_n;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   mem_bus_ctrl dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .if_addr(if_addr), .if_inst(if_inst),
      .stall_request_from_mem(stall), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_wdata_oe(sram_wdata_oe), .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   typedef struct {
      logic        rst, req, we;
      logic [17:0] addr;
      logic [15:0] wdata, srd;
      logic        e_stall, e_ce_n, e_oe_n, e_we_n, e_woe;
      logic [17:0] e_addr;
      logic [15:0] e_inst, e_rd;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t v(logic r, logic q, logic w, logic [17:0] a, logic [15:0] wd,
                              logic [15:0] sd, logic es, logic ec, logic eo, logic ew,
                              logic ewoe, logic [17:0] ea, logic [15:0] ei, logic [15:0] er);
      vec_t t;
      t.rst = r; t.req = q; t.we = w; t.addr = a; t.wdata = wd; t.srd = sd;
      t.e_stall = es; t.e_ce_n = ec; t.e_oe_n = eo; t.e_we_n = ew; t.e_woe = ewoe;
      t.e_addr = ea; t.e_inst = ei; t.e_rd = er;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic q, input logic w, input logic [17:0] a,
                        input logic [15:0] wd, input logic [15:0] sd);
      @(negedge clk);
      rst = r; mem_req = q; mem_we = w; mem_addr = a; mem_wdata = wd; sram_rdata = sd;
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      if_addr = 18'h00010; sram_rdata = '0;
      //          rst req we addr      wdata    srd      stall ce oe we woe addr      inst     rdata
      vecs[0]  = v(1, 1, 0, 18'h0BF00, 16'h0000, 16'h4A12, 0, 1, 1, 1, 0, 18'h00010, 16'h0800, 16'h0000);
      vecs[1]  = v(1, 1, 0, 18'h0BF00, 16'h0000, 16'h4A12, 0, 1, 1, 1, 0, 18'h00010, 16'h0800, 16'h0000);
      vecs[2]  = v(0, 0, 0, 18'h0BF00, 16'h0000, 16'h4A12, 0, 0, 0, 1, 0, 18'h00010, 16'h4A12, 16'h0000);
      vecs[3]  = v(0, 1, 0, 18'h0BF00, 16'h0000, 16'h4A12, 1, 0, 0, 1, 0, 18'h00010, 16'h0800, 16'h0000);
      vecs[4]  = v(0, 1, 0, 18'h0BF00, 16'h0000, 16'h1234, 1, 0, 0, 1, 0, 18'h0BF00, 16'h0800, 16'h0000);
      vecs[5]  = v(0, 1, 0, 18'h0BF00, 16'h0000, 16'h1234, 1, 0, 0, 1, 0, 18'h0BF00, 16'h0800, 16'h0000);
      vecs[6]  = v(0, 1, 0, 18'h0BF00, 16'h0000, 16'h1234, 1, 0, 0, 1, 0, 18'h0BF00, 16'h0800, 16'h0000);
      vecs[7]  = v(0, 1, 0, 18'h0BF00, 16'h0000, 16'h5555, 0, 0, 0, 1, 0, 18'h00010, 16'h5555, 16'h1234);
      vecs[8]  = v(0, 1, 1, 18'h00200, 16'hBEEF, 16'h5555, 1, 0, 0, 1, 0, 18'h00010, 16'h0800, 16'h1234);
      vecs[9]  = v(0, 1, 1, 18'h00200, 16'hBEEF, 16'h7777, 1, 0, 1, 1, 1, 18'h00200, 16'h0800, 16'h1234);
      vecs[10] = v(0, 1, 1, 18'h00200, 16'hBEEF, 16'h7777, 1, 0, 1, 0, 1, 18'h00200, 16'h0800, 16'h1234);
      vecs[11] = v(0, 1, 1, 18'h00200, 16'hBEEF, 16'h7777, 1, 0, 1, 1, 1, 18'h00200, 16'h0800, 16'h1234);
      vecs[12] = v(0, 1, 1, 18'h00200, 16'hBEEF, 16'h7777, 0, 0, 0, 1, 0, 18'h00010, 16'h7777, 16'h1234);
      vecs[13] = v(0, 0, 0, 18'h00200, 16'hBEEF, 16'h7777, 0, 0, 0, 1, 0, 18'h00010, 16'h7777, 16'h1234);
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].srd);
         chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d ce_n", i), 32'(sram_ce_n), 32'(vecs[i].e_ce_n));
         chk($sformatf("v%0d oe_n", i), 32'(sram_oe_n), 32'(vecs[i].e_oe_n));
         chk($sformatf("v%0d we_n", i), 32'(sram_we_n), 32'(vecs[i].e_we_n));
         chk($sformatf("v%0d wdata_oe", i), 32'(sram_wdata_oe), 32'(vecs[i].e_woe));
         chk($sformatf("v%0d sram_addr", i), 32'(sram_addr), 32'(vecs[i].e_addr));
         chk($sformatf("v%0d if_inst", i), 32'(if_inst), 32'(vecs[i].e_inst));
         chk($sformatf("v%0d mem_rdata", i), 32'(mem_rdata), 32'(vecs[i].e_rd));
         if (vecs[i].e_woe) chk($sformatf("v%0d sram_wdata", i), 32'(sram_wdata), 32'(vecs[i].wdata));
      end
      // reset in the strobe cycle of a store aborts it immediately
      drive(0, 1, 1, 18'h00300, 16'hCAFE, 16'h0000);
      drive(0, 1, 1, 18'h00300, 16'hCAFE, 16'h0000);
      drive(1, 1, 1, 18'h00300, 16'hCAFE, 16'h0000);
      chk("rst_mid we_n", 32'(sram_we_n), 32'd1);
      chk("rst_mid stall", 32'(stall), 32'd0);
      chk("rst_mid wdata_oe", 32'(sram_wdata_oe), 32'd0);
      chk("rst_mid if_inst", 32'(if_inst), 32'h0800);
      drive(0, 0, 0, 18'h00300, 16'h0000, 16'h3C3C);
      chk("post_rst stall", 32'(stall), 32'd0);
      chk("post_rst addr", 32'(sram_addr), 32'h00010);
      chk("post_rst oe_n", 32'(sram_oe_n), 32'd0);
      chk("post_rst if_inst", 32'(if_inst), 32'h3C3C);
      chk("post_rst mem_rdata", 32'(mem_rdata), 32'h0000);
      // load with a bounded stall count
      n = 0;
      for (int c = 0; c < 20; c++) begin
         drive(0, 1, 0, 18'h00ABC, 16'h0000, 16'h9ABC);
         if (!stall) break;
         n++;
      end
      chk("load stall_cycles", 32'(n), 32'd4);
      chk("load mem_rdata", 32'(mem_rdata), 32'h9ABC);
      chk("load done if_inst", 32'(if_inst), 32'h9ABC);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
